// File: rtl/astropix_pkg.sv
// Shared AstroPix readout definitions.
//   IDLE_BYTE_C    : idle byte in transmit alignment
//   unpack_state_t : readout unpacker FSM states
//   realign_byte   : stored (rotated) byte -> transmit-aligned byte
package astropix_pkg;

    localparam logic [7:0] IDLE_BYTE_C = 8'hBC;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        POP   = 2'd1,
        LATCH = 2'd2,
        SCAN  = 2'd3
    } unpack_state_t;

    // The readout stores each byte rotated right by two: s = {o[1:0], o[7:2]}.
    function automatic logic [7:0] realign_byte(input logic [7:0] s);
        return {s[5:0], s[7:6]};
    endfunction

endpackage

// File: rtl/spi_readout_unpacker.sv
// SPI readout unpacker: pops 64-bit words from the readout FIFO, realigns
// each byte (byte 7 first), drops idle bytes and streams hit bytes out with
// a frame-end marker on the last byte before an idle byte or a flush.
//
// Ports:
//   clock, reset    : block clock, synchronous active-high reset
//   fifo_data       : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty      : FIFO empty
//   fifo_rd_en      : single-cycle pop strobe
//   flush           : one-cycle pulse, closes the open frame
//   out_data/out_valid/out_ready/out_last : byte stream
//   idle_count      : saturating count of consumed idle bytes
//
// Optional build macro: SPI_UNPACK_IDLE_CNT_EN enables the idle counter;
// otherwise idle_count is tied to zero.
module spi_readout_unpacker
    import astropix_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_C
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic        flush,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] idle_count
);

    unpack_state_t state, state_next;

    logic [63:0] word_q;
    logic [2:0]  index_q;
    logic        pend_valid;
    logic [7:0]  pend_byte;
    logic        flush_q;

    logic [7:0]  scan_byte;
    logic        byte_is_idle;
    logic        slot_free;
    logic        scan_emit_need;
    logic        scan_emit;
    logic        scan_adv;
    logic        flush_any;
    logic        flush_fire;

    assign scan_byte = realign_byte(word_q[{index_q, 3'b000} +: 8]);

    always_comb begin
        state_next     = state;
        fifo_rd_en     = 1'b0;
        slot_free      = !out_valid || out_ready;
        byte_is_idle   = (scan_byte == IDLE_BYTE);
        // With the hold register full every scanned byte forces an emit.
        scan_emit_need = (state == SCAN) && pend_valid;
        scan_emit      = scan_emit_need && slot_free;
        scan_adv       = (state == SCAN) && (!pend_valid || slot_free);
        flush_any      = flush || flush_q;
        // Flush yields to a scan emit; it waits in flush_q until serviced.
        flush_fire     = flush_any && pend_valid && slot_free && !scan_emit_need;

        case (state)
            WAIT: begin
                if (!fifo_empty) state_next = POP;
            end
            POP: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_next = LATCH;
                end else begin
                    state_next = WAIT;
                end
            end
            LATCH: begin
                state_next = SCAN;
            end
            SCAN: begin
                if (scan_adv && (index_q == 3'd0)) state_next = WAIT;
            end
            default: state_next = WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= WAIT;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_q     <= '0;
            index_q    <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
            flush_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            if (state == LATCH) begin
                word_q  <= fifo_data;
                index_q <= 3'd7;
            end else if (scan_adv) begin
                index_q <= index_q - 3'd1;
            end

            if (scan_emit) begin
                out_valid <= 1'b1;
                out_data  <= pend_byte;
                out_last  <= byte_is_idle;
            end else if (flush_fire) begin
                out_valid <= 1'b1;
                out_data  <= pend_byte;
                out_last  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (scan_adv) begin
                if (byte_is_idle) begin
                    pend_valid <= 1'b0;
                end else begin
                    pend_valid <= 1'b1;
                    pend_byte  <= scan_byte;
                end
            end else if (flush_fire) begin
                pend_valid <= 1'b0;
            end

            // A flush seen with an empty hold register is discarded.
            flush_q <= flush_any && pend_valid && !flush_fire;
        end
    end

`ifdef SPI_UNPACK_IDLE_CNT_EN
    logic [15:0] idle_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else if (scan_adv && byte_is_idle && (idle_cnt_q != '1)) begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
        end
    end

    assign idle_count = idle_cnt_q;
`else
    assign idle_count = '0;
`endif

endmodule
